// File: rtl/otl_bus_arbiter_pkg.sv
// Shared types and constants for the core register-bus arbiter: FSM state encoding,
// timeout error read-data pattern, core address map and the round-robin pointer helper.
`ifndef OTL_ARB_ERR_DATA
`define OTL_ARB_ERR_DATA 32'hDEAD_BEEF
`endif

package otl_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        OTL_ARB_IDLE = 2'd0,
        OTL_ARB_WR   = 2'd1,
        OTL_ARB_RD   = 2'd2
    } arb_state_e;

    localparam logic [31:0] ARB_ERR_DATA = `OTL_ARB_ERR_DATA;

    // Core address map seen by the downstream decoder.
    localparam logic [31:0] OTL_ADC_BASE = 32'h0000_1000;
    localparam logic [31:0] OTL_DAC_BASE = 32'h0000_2000;
    localparam logic [31:0] OTL_TRX_BASE = 32'h0000_3000;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/otl_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: scans the request vector upward from the pointer,
// wrapping at NREQ-1, and returns the first requester as one-hot and as an index.
module otl_bus_arbiter_rr_pick
    import otl_bus_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] pick_onehot,
    output logic [IDXW-1:0] pick_idx,
    output logic            pick_any
);

    logic [IDXW:0] cand_s;

    // Priority scan starting at the pointer; first hit wins.
    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        pick_any    = 1'b0;
        cand_s      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, ptr} + (IDXW+1)'(k);
            if (cand_s >= (IDXW+1)'(NREQ)) begin
                cand_s = cand_s - (IDXW+1)'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!pick_any && req[cand_s[IDXW-1:0]]) begin
                pick_any                        = 1'b1;
                pick_idx                        = cand_s[IDXW-1:0];
                pick_onehot[cand_s[IDXW-1:0]]   = 1'b1;
            end else begin
                pick_any = pick_any;
            end
        end
    end

endmodule

// File: rtl/otl_bus_arbiter.sv
// Round-robin arbiter sharing the core register bus between NREQ requesters, one
// transaction in flight. Optional slave timeout enabled by defining OTL_ARB_TIMEOUT_EN.
module otl_bus_arbiter
    import otl_bus_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ADDRW   = 32,
    parameter int DATAW   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_wrvalid,
    input  logic [NREQ*ADDRW-1:0]  req_wraddr,
    input  logic [NREQ*DATAW-1:0]  req_wrdata,
    output logic [NREQ-1:0]        req_wrready,
    input  logic [NREQ-1:0]        req_rdvalid,
    input  logic [NREQ*ADDRW-1:0]  req_rdaddr,
    output logic [NREQ-1:0]        req_rdack,
    output logic [DATAW-1:0]       req_rddata,
    output logic [DATAW-1:0]       m_wrdata,
    output logic [ADDRW-1:0]       m_wraddr,
    output logic                   m_wrvalid,
    input  logic                   m_wrready,
    output logic [ADDRW-1:0]       m_rdaddr,
    output logic                   m_rdready,
    input  logic [DATAW-1:0]       m_rddata,
    input  logic                   m_rdvalid,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        state_r;
    arb_state_e        state_nx_s;
    logic [IDXW-1:0]   ptr_r;
    logic [IDXW-1:0]   gidx_r;
    logic [NREQ-1:0]   grant_r;
    logic [ADDRW-1:0]  wraddr_r;
    logic [ADDRW-1:0]  rdaddr_r;
    logic [DATAW-1:0]  wrdata_r;
    logic              wrvalid_r;
    logic              rdready_r;
    logic              busy_r;
    logic [NREQ-1:0]   req_any_s;
    logic [NREQ-1:0]   pick_onehot_s;
    logic [IDXW-1:0]   pick_idx_s;
    logic              pick_any_s;
    logic              done_s;
    logic              to_hit_s;

    assign req_any_s = req_wrvalid | req_rdvalid;

    otl_bus_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req         (req_any_s),
        .ptr         (ptr_r),
        .pick_onehot (pick_onehot_s),
        .pick_idx    (pick_idx_s),
        .pick_any    (pick_any_s)
    );

`ifdef OTL_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] cnt_r;

    // Slave wait counter: zero in the first granted cycle, counts while granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (state_r == OTL_ARB_IDLE) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNTW'(1);
        end
    end

    assign to_hit_s = (state_r != OTL_ARB_IDLE) && (cnt_r == CNTW'(TIMEOUT - 1));
`else
    assign to_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= OTL_ARB_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state: write wins over read for the same requester; mandatory IDLE between grants.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            OTL_ARB_IDLE: begin
                if (pick_any_s) begin
                    if (req_wrvalid[pick_idx_s]) begin
                        state_nx_s = OTL_ARB_WR;
                    end else begin
                        state_nx_s = OTL_ARB_RD;
                    end
                end else begin
                    state_nx_s = OTL_ARB_IDLE;
                end
            end
            OTL_ARB_WR,
            OTL_ARB_RD: state_nx_s = done_s ? OTL_ARB_IDLE : state_r;
            default:    state_nx_s = OTL_ARB_IDLE;
        endcase
    end

    // Requester handshake outputs; a slave handshake in the same cycle beats the timeout.
    always_comb begin
        req_wrready = '0;
        req_rdack   = '0;
        req_rddata  = '0;
        timeout_err = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            OTL_ARB_WR: begin
                if (m_wrready) begin
                    req_wrready[gidx_r] = 1'b1;
                    done_s              = 1'b1;
                end else if (to_hit_s) begin
                    req_wrready[gidx_r] = 1'b1;
                    timeout_err         = 1'b1;
                    done_s              = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            OTL_ARB_RD: begin
                if (m_rdvalid) begin
                    req_rdack[gidx_r] = 1'b1;
                    req_rddata        = m_rddata;
                    done_s            = 1'b1;
                end else if (to_hit_s) begin
                    req_rdack[gidx_r] = 1'b1;
                    req_rddata        = DATAW'(ARB_ERR_DATA);
                    timeout_err       = 1'b1;
                    done_s            = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    // Grant capture, bus-side registered outputs and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r     <= '0;
            gidx_r    <= '0;
            grant_r   <= '0;
            wraddr_r  <= '0;
            rdaddr_r  <= '0;
            wrdata_r  <= '0;
            wrvalid_r <= 1'b0;
            rdready_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            wrvalid_r <= (state_nx_s == OTL_ARB_WR);
            rdready_r <= (state_nx_s == OTL_ARB_RD);
            busy_r    <= (state_nx_s != OTL_ARB_IDLE);
            if ((state_r == OTL_ARB_IDLE) && pick_any_s) begin
                gidx_r  <= pick_idx_s;
                grant_r <= pick_onehot_s;
                if (req_wrvalid[pick_idx_s]) begin
                    wraddr_r <= req_wraddr[pick_idx_s*ADDRW +: ADDRW];
                    wrdata_r <= req_wrdata[pick_idx_s*DATAW +: DATAW];
                end else begin
                    rdaddr_r <= req_rdaddr[pick_idx_s*ADDRW +: ADDRW];
                end
            end else if (done_s) begin
                grant_r <= '0;
                ptr_r   <= IDXW'(rr_next(32'(gidx_r), 32'(NREQ)));
            end else begin
                grant_r <= grant_r;
            end
        end
    end

    assign m_wrvalid = wrvalid_r;
    assign m_rdready = rdready_r;
    assign m_wraddr  = wraddr_r;
    assign m_wrdata  = wrdata_r;
    assign m_rdaddr  = rdaddr_r;
    assign grant     = grant_r;
    assign busy      = busy_r;

endmodule
